// File: rtl/lane_buf_pkg.sv
// Shared types and default sizing for the lane buffer scheduler.
// Optional feature macro used by the top: LANE_BUF_STALE_CNT_EN.
package lane_buf_pkg;

    localparam int DEFAULT_DEPTH  = 160;
    localparam int DEFAULT_ADDR_W = 8;

    // Scheduler FSM: filling the write bank, waiting for a frame boundary
    // with a complete bank, and the single-cycle bank exchange.
    typedef enum logic [1:0] {
        FILL = 2'd0,
        FULL = 2'd1,
        SWAP = 2'd2
    } state_t;

endpackage

// File: rtl/lane_buf_addr_ctr.sv
// Wrapping address counter: counts 0..DEPTH-1 on en, clr forces zero and
// wins over en, synchronous active-high reset.
module lane_buf_addr_ctr #(
    parameter int DEPTH  = 160,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              clr,
    output logic [ADDR_W-1:0] cnt
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    // Counter register: reset, then clear, then wrap-around increment.
    always_ff @(posedge clk) begin
        if (resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/lane_buffer_scheduler.sv
// Double-buffered lane scheduler: one bank is filled by the producer while
// the other is displayed; banks exchange at a frame boundary once the write
// bank holds a complete frame. RAMs and the read-data mux live outside.
// Optional feature: define LANE_BUF_STALE_CNT_EN to add the stale_cnt port,
// which counts frame boundaries that found the write bank still filling.
//
// Handshake: an entry is transferred in every cycle where wr_valid and
// wr_ready are both high; wr_ready does not depend on wr_valid, and the
// producer must hold its entry until it sees the transfer.
module lane_buffer_scheduler
    import lane_buf_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              frame_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic              rd_active,
    output logic              ram0_we,
    output logic              ram1_we,
    output logic              ram0_re,
    output logic              ram1_re,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_bank,
    output logic              swap_done,
    output state_t            fsm_state
`ifdef LANE_BUF_STALE_CNT_EN
    ,
    output logic [7:0]        stale_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   wr_last;
    logic   swap_enter;

    // The write bank is always ~rd_bank, so only the accept needs resolving.
    assign accept     = wr_valid & ~resetn & (state == FILL);
    assign wr_last    = (wr_addr == LAST);
    assign swap_enter = (state != SWAP) & (next_state == SWAP);
    assign fsm_state  = state;

    // Write address: advances on every accepted entry, wraps at frame end.
    lane_buf_addr_ctr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ctr (
        .clk    (clk),
        .resetn (resetn),
        .en     (accept),
        .clr    (1'b0),
        .cnt    (wr_addr)
    );

    // Read address: restarts at every frame boundary and stays at 0 through
    // the swap so the new bank is shown from its first entry.
    lane_buf_addr_ctr #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ctr (
        .clk    (clk),
        .resetn (resetn),
        .en     (rd_active),
        .clr    (frame_start | (state == SWAP)),
        .cnt    (rd_addr)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Next state: a completed frame waits in FULL unless the boundary
    // arrives on the very cycle of the last accept.
    always_comb begin
        next_state = state;
        unique case (state)
            FILL: begin
                if (accept && wr_last) begin
                    next_state = frame_start ? SWAP : FULL;
                end
            end
            FULL: begin
                if (frame_start) begin
                    next_state = SWAP;
                end
            end
            SWAP:    next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    // Outputs: everything held low in reset; reads blanked during the swap.
    always_comb begin
        wr_ready  = 1'b0;
        swap_done = 1'b0;
        ram0_we   = 1'b0;
        ram1_we   = 1'b0;
        ram0_re   = 1'b0;
        ram1_re   = 1'b0;
        if (!resetn) begin
            wr_ready  = (state == FILL);
            swap_done = (state == SWAP);
            ram0_we   = accept & rd_bank;
            ram1_we   = accept & ~rd_bank;
            if (state != SWAP) begin
                ram0_re = rd_active & ~rd_bank;
                ram1_re = rd_active & rd_bank;
            end
        end
    end

    // Displayed bank flips as the FSM enters SWAP, so it is already the new
    // bank during the swap cycle itself.
    always_ff @(posedge clk) begin
        if (resetn) begin
            rd_bank <= 1'b0;
        end else if (swap_enter) begin
            rd_bank <= ~rd_bank;
        end
    end

`ifdef LANE_BUF_STALE_CNT_EN
    // Stale-frame counter: a boundary seen while filling that does not also
    // complete the frame means the display repeats its current bank.
    always_ff @(posedge clk) begin
        if (resetn) begin
            stale_cnt <= 8'd0;
        end else if ((state == FILL) && frame_start && !(accept && wr_last)
                     && (stale_cnt != 8'd255)) begin
            stale_cnt <= stale_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lane_buffer_scheduler.sv
// Self-checking bench for lane_buffer_scheduler at DEPTH=4: directed
// scenarios followed by randomized traffic against a behavioural model.
module tb_lane_buffer_scheduler;
    import lane_buf_pkg::*;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 8;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn = 1'b1;
    logic              frame_start = 1'b0;
    logic              wr_valid = 1'b0;
    logic              rd_active = 1'b0;
    logic              wr_ready;
    logic              ram0_we, ram1_we, ram0_re, ram1_re;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              rd_bank, swap_done;
    state_t            fsm_state;
`ifdef LANE_BUF_STALE_CNT_EN
    logic [7:0]        stale_cnt;
`endif

    lane_buffer_scheduler #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .rd_active   (rd_active),
        .ram0_we     (ram0_we),
        .ram1_we     (ram1_we),
        .ram0_re     (ram0_re),
        .ram1_re     (ram1_re),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr),
        .rd_bank     (rd_bank),
        .swap_done   (swap_done),
        .fsm_state   (fsm_state)
`ifdef LANE_BUF_STALE_CNT_EN
        ,
        .stale_cnt   (stale_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    // phase: 0 = filling, 1 = full and waiting, 2 = swapping
    int m_bank, m_words, m_phase, m_rpos, m_stale;

    logic              exp_wr_ready, exp_we0, exp_we1, exp_re0, exp_re1, exp_swap;
    logic [ADDR_W-1:0] exp_wr_addr, exp_rd_addr;
    logic              exp_bank;
    logic [7:0]        exp_stale;
    state_t            exp_state;

    function automatic void model_reset();
        m_bank = 0; m_words = 0; m_phase = 0; m_rpos = 0; m_stale = 0;
    endfunction

    // Expected outputs for the current model state and driven inputs.
    function automatic void predict();
        bit acc;
        exp_wr_addr = ADDR_W'(m_words);
        exp_rd_addr = ADDR_W'(m_rpos);
        exp_bank    = m_bank[0];
        exp_stale   = 8'(m_stale);
        exp_state   = (m_phase == 0) ? FILL : (m_phase == 1) ? FULL : SWAP;
        if (resetn) begin
            exp_wr_ready = 0; exp_we0 = 0; exp_we1 = 0;
            exp_re0 = 0; exp_re1 = 0; exp_swap = 0;
        end else begin
            exp_wr_ready = (m_phase == 0);
            acc          = wr_valid && exp_wr_ready;
            exp_we0      = acc && (m_bank == 1);
            exp_we1      = acc && (m_bank == 0);
            exp_re0      = (m_phase != 2) && rd_active && (m_bank == 0);
            exp_re1      = (m_phase != 2) && rd_active && (m_bank == 1);
            exp_swap     = (m_phase == 2);
        end
    endfunction

    // Model update at a rising edge, from the inputs of the ending cycle.
    function automatic void advance();
        bit acc, completing;
        if (resetn) begin
            model_reset();
            return;
        end
        acc        = wr_valid && (m_phase == 0);
        completing = acc && (m_words == DEPTH - 1);
        if (frame_start || m_phase == 2) m_rpos = 0;
        else if (rd_active)              m_rpos = (m_rpos + 1) % DEPTH;
        case (m_phase)
            0: begin
                if (frame_start && !completing && m_stale < 255) m_stale++;
                if (completing) begin
                    m_words = 0;
                    if (frame_start) begin m_phase = 2; m_bank ^= 1; end
                    else m_phase = 1;
                end else if (acc) begin
                    m_words++;
                end
            end
            1: if (frame_start) begin m_phase = 2; m_bank ^= 1; end
            default: m_phase = 0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input bit rst, input bit fs, input bit wv, input bit ra);
        @(negedge clk);
        resetn = rst; frame_start = fs; wr_valid = wv; rd_active = ra;
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        advance();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive(1, 0, 1, 1); tick();
        drive(1, 1, 1, 1);
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready got=%0h exp=0", wr_ready); end
        n_checks++; if ({ram0_we, ram1_we} !== 2'b00) begin n_fail++; $display("FAIL rst_we got=%b exp=00", {ram0_we, ram1_we}); end
        n_checks++; if ({ram0_re, ram1_re} !== 2'b00) begin n_fail++; $display("FAIL rst_re got=%b exp=00", {ram0_re, ram1_re}); end
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL rst_swap_done got=%0h exp=0", swap_done); end
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (fsm_state !== FILL) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", fsm_state, FILL); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL rst_rd_bank got=%0h exp=0", rd_bank); end
        n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); end
        n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL rst_rd_addr got=%0d exp=0", rd_addr); end
`ifdef LANE_BUF_STALE_CNT_EN
        n_checks++; if (stale_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_stale got=%0d exp=0", stale_cnt); end
`endif
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 0, 1, 0);
            n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got=%0h exp=1", i, wr_ready); end
            n_checks++; if ({ram0_we, ram1_we} !== 2'b01) begin n_fail++; $display("FAIL fill_we[%0d] got=%b exp=01", i, {ram0_we, ram1_we}); end
            n_checks++; if (wr_addr !== ADDR_W'(i)) begin n_fail++; $display("FAIL fill_addr[%0d] got=%0d exp=%0d", i, wr_addr, i); end
            tick();
        end
        drive(0, 0, 1, 0);
        n_checks++; if (fsm_state !== FULL) begin n_fail++; $display("FAIL full_state got=%0d exp=%0d", fsm_state, FULL); end
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%0h exp=0", wr_ready); end
        n_checks++; if ({ram0_we, ram1_we} !== 2'b00) begin n_fail++; $display("FAIL full_we got=%b exp=00", {ram0_we, ram1_we}); end
        n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL full_wr_addr got=%0d exp=0", wr_addr); end
        tick();
    endtask

    task automatic test_swap();
        drive(0, 1, 0, 0);
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL swap_early got=%0h exp=0", swap_done); end
        tick();
        drive(0, 0, 0, 1);
        n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL swap_done got=%0h exp=1", swap_done); end
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL swap_bank got=%0h exp=1", rd_bank); end
        n_checks++; if ({ram0_re, ram1_re} !== 2'b00) begin n_fail++; $display("FAIL swap_re got=%b exp=00", {ram0_re, ram1_re}); end
        n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL swap_rd_addr got=%0d exp=0", rd_addr); end
        tick();
    endtask

    task automatic test_read_wrap();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, (i == 0), 1);
            n_checks++; if (rd_addr !== ADDR_W'(i % DEPTH)) begin n_fail++; $display("FAIL rd_addr[%0d] got=%0d exp=%0d", i, rd_addr, i % DEPTH); end
            n_checks++; if ({ram0_re, ram1_re} !== 2'b01) begin n_fail++; $display("FAIL rd_re[%0d] got=%b exp=01", i, {ram0_re, ram1_re}); end
            if (i == 0) begin
                n_checks++; if (fsm_state !== FILL) begin n_fail++; $display("FAIL post_swap_state got=%0d exp=%0d", fsm_state, FILL); end
                n_checks++; if ({ram0_we, ram1_we} !== 2'b10) begin n_fail++; $display("FAIL post_swap_we got=%b exp=10", {ram0_we, ram1_we}); end
                n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL post_swap_wr_addr got=%0d exp=0", wr_addr); end
            end
            tick();
        end
    endtask

    task automatic test_stale();
        drive(0, 0, 1, 0);
        n_checks++; if (wr_addr !== ADDR_W'(1)) begin n_fail++; $display("FAIL stale_pre_addr got=%0d exp=1", wr_addr); end
        tick();
        drive(0, 1, 0, 0);
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL stale_swap got=%0h exp=0", swap_done); end
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (swap_done !== 1'b0) begin n_fail++; $display("FAIL stale_no_swap got=%0h exp=0", swap_done); end
        n_checks++; if (rd_bank !== 1'b1) begin n_fail++; $display("FAIL stale_bank got=%0h exp=1", rd_bank); end
        n_checks++; if (rd_addr !== '0) begin n_fail++; $display("FAIL stale_rd_addr got=%0d exp=0", rd_addr); end
        n_checks++; if (fsm_state !== FILL) begin n_fail++; $display("FAIL stale_state got=%0d exp=%0d", fsm_state, FILL); end
`ifdef LANE_BUF_STALE_CNT_EN
        n_checks++; if (stale_cnt !== 8'd1) begin n_fail++; $display("FAIL stale_cnt got=%0d exp=1", stale_cnt); end
`endif
        tick();
        drive(0, 0, 1, 0);
        n_checks++; if (wr_addr !== ADDR_W'(2)) begin n_fail++; $display("FAIL stale_resume_addr got=%0d exp=2", wr_addr); end
        n_checks++; if ({ram0_we, ram1_we} !== 2'b10) begin n_fail++; $display("FAIL stale_resume_we got=%b exp=10", {ram0_we, ram1_we}); end
        tick();
    endtask

    task automatic test_direct_swap();
        drive(0, 1, 1, 0);
        n_checks++; if (wr_addr !== ADDR_W'(3)) begin n_fail++; $display("FAIL dswap_addr got=%0d exp=3", wr_addr); end
        n_checks++; if (ram0_we !== 1'b1) begin n_fail++; $display("FAIL dswap_we got=%0h exp=1", ram0_we); end
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (fsm_state !== SWAP) begin n_fail++; $display("FAIL dswap_state got=%0d exp=%0d", fsm_state, SWAP); end
        n_checks++; if (swap_done !== 1'b1) begin n_fail++; $display("FAIL dswap_done got=%0h exp=1", swap_done); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL dswap_bank got=%0h exp=0", rd_bank); end
`ifdef LANE_BUF_STALE_CNT_EN
        n_checks++; if (stale_cnt !== 8'd1) begin n_fail++; $display("FAIL dswap_stale got=%0d exp=1", stale_cnt); end
`endif
        tick();
        drive(0, 0, 0, 0);
        n_checks++; if (fsm_state !== FILL) begin n_fail++; $display("FAIL dswap_return got=%0d exp=%0d", fsm_state, FILL); end
        tick();
    endtask

    task automatic test_reset_midfill();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0); tick();
        end
        drive(1, 0, 1, 1);
        n_checks++; if ({wr_ready, ram0_we, ram1_we, ram0_re, ram1_re} !== 5'b0) begin n_fail++; $display("FAIL midrst_outs got=%b exp=00000", {wr_ready, ram0_we, ram1_we, ram0_re, ram1_re}); end
        tick();
        drive(0, 0, 1, 0);
        n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL midrst_addr got=%0d exp=0", wr_addr); end
        n_checks++; if ({ram0_we, ram1_we} !== 2'b01) begin n_fail++; $display("FAIL midrst_we got=%b exp=01", {ram0_we, ram1_we}); end
        n_checks++; if (rd_bank !== 1'b0) begin n_fail++; $display("FAIL midrst_bank got=%0h exp=0", rd_bank); end
`ifdef LANE_BUF_STALE_CNT_EN
        n_checks++; if (stale_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_stale got=%0d exp=0", stale_cnt); end
`endif
        tick();
    endtask

    task automatic test_random();
        bit rst, fs, wv, ra;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            fs  = ($urandom_range(0, 5) == 0);
            wv  = ($urandom_range(0, 3) != 0);
            ra  = ($urandom_range(0, 1) == 1);
            drive(rst, fs, wv, ra);
            n_checks++; if (wr_ready !== exp_wr_ready) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0h exp=%0h", c, wr_ready, exp_wr_ready); end
            n_checks++; if ({ram0_we, ram1_we} !== {exp_we0, exp_we1}) begin n_fail++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, {ram0_we, ram1_we}, {exp_we0, exp_we1}); end
            n_checks++; if ({ram0_re, ram1_re} !== {exp_re0, exp_re1}) begin n_fail++; $display("FAIL rnd_re c=%0d got=%b exp=%b", c, {ram0_re, ram1_re}, {exp_re0, exp_re1}); end
            n_checks++; if (swap_done !== exp_swap) begin n_fail++; $display("FAIL rnd_swap c=%0d got=%0h exp=%0h", c, swap_done, exp_swap); end
            n_checks++; if (wr_addr !== exp_wr_addr) begin n_fail++; $display("FAIL rnd_wr_addr c=%0d got=%0d exp=%0d", c, wr_addr, exp_wr_addr); end
            n_checks++; if (rd_addr !== exp_rd_addr) begin n_fail++; $display("FAIL rnd_rd_addr c=%0d got=%0d exp=%0d", c, rd_addr, exp_rd_addr); end
            n_checks++; if (rd_bank !== exp_bank) begin n_fail++; $display("FAIL rnd_bank c=%0d got=%0h exp=%0h", c, rd_bank, exp_bank); end
            n_checks++; if (fsm_state !== exp_state) begin n_fail++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, fsm_state, exp_state); end
`ifdef LANE_BUF_STALE_CNT_EN
            n_checks++; if (stale_cnt !== exp_stale) begin n_fail++; $display("FAIL rnd_stale c=%0d got=%0d exp=%0d", c, stale_cnt, exp_stale); end
`endif
            tick();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_swap();
        test_read_wrap();
        test_stale();
        test_direct_swap();
        test_reset_midfill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_buffer_scheduler.md
LANE_BUFFER_SCHEDULER -- requirements
Module: lane_buffer_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 160: entries per bank, one frame of lane data.
REQ-002 SHALL have parameter ADDR_W, default 8: address width, with DEPTH <= 2**ADDR_W.
REQ-003 SHALL have port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 SHALL have port resetn, input, 1: synchronous reset, active-high (1 = reset).
REQ-005 SHALL have port frame_start, input, 1: one-cycle pulse from the display side at each frame boundary.
REQ-006 SHALL have port wr_valid, input, 1: producer offers one entry this cycle.
REQ-007 SHALL have port wr_ready, output, 1: the scheduler accepts the entry.
REQ-008 SHALL have port rd_active, input, 1: display requests the next entry.
REQ-009 SHALL have ports ram0_we and ram1_we, output, 1 each: per-bank write enables.
REQ-010 SHALL have ports ram0_re and ram1_re, output, 1 each: per-bank read enables.
REQ-011 SHALL have ports wr_addr and rd_addr, output, ADDR_W each: shared bank addresses.
REQ-012 SHALL have port rd_bank, output, 1: the bank being displayed; it also drives the external read-data mux select.
REQ-013 SHALL have port swap_done, output, 1: one-cycle pulse on each bank swap.
REQ-014 SHALL have port stale_cnt, output, 8: count of frames shown without a fresh buffer (present only under REQ-030).

Function
REQ-015 SHALL keep the write bank equal to ~rd_bank at all times, so the two banks are never both written or both read.
REQ-016 SHALL implement FSM states FILL, FULL and SWAP.
REQ-017 In FILL: wr_ready=1; an accept (wr_valid&wr_ready) asserts the write-bank we combinationally at wr_addr, then increments wr_addr.
REQ-018 An accept at wr_addr==DEPTH-1 SHALL set wr_addr to 0 and move to FULL, or to SWAP if frame_start is high in the same cycle.
REQ-019 In FULL: wr_ready=0 and both we=0; frame_start moves the FSM to SWAP.
REQ-020 SWAP SHALL last exactly one cycle: toggle rd_bank, force rd_addr=0, swap_done=1, both re=0, then return to FILL.
REQ-021 frame_start in FILL, other than the completing accept of REQ-018, SHALL NOT swap; the display re-reads the current bank.
REQ-022 Outside SWAP, the re of bank rd_bank SHALL equal rd_active and the other re SHALL be 0.
REQ-023 rd_addr SHALL increment on each rd_active cycle and wrap from DEPTH-1 to 0.
REQ-024 frame_start SHALL clear rd_addr to 0, taking priority over increment.
REQ-025 Write latency SHALL be 0 cycles (we is combinational); the swap SHALL take effect on the cycle after the frame_start edge.

Reset
REQ-026 While resetn=1 at a clk edge, the block SHALL load state=FILL, rd_bank=0, wr_addr=0, rd_addr=0, stale_cnt=0.
REQ-027 During reset, swap_done, all we and all re SHALL be 0 and wr_ready SHALL be 0.
REQ-028 Reset asserted mid-fill SHALL discard the partial frame; after reset, filling restarts at address 0 of bank 1.

Configuration
REQ-029 Macro LANE_BUF_STALE_CNT_EN SHALL select the stale-frame counter.
REQ-030 With LANE_BUF_STALE_CNT_EN defined: stale_cnt increments, saturating at 255, on each frame_start that occurs in FILL and does not complete a swap.
REQ-031 Without LANE_BUF_STALE_CNT_EN: the stale_cnt port and its counter logic are absent.

Structure
REQ-032 A shared package lane_buf_pkg SHALL hold the FSM state typedef (FILL/FULL/SWAP) and the default DEPTH and ADDR_W constants.
REQ-033 A single sub-module, lane_buf_addr_ctr, SHALL implement the wrapping address counter (enable, clear, DEPTH-1 wrap) and be instantiated twice, once for writes and once for reads.
REQ-034 The RAMs and the data mux SHALL remain outside this block.

Verification (DEPTH=4)
REQ-035 Reset, then 4 accepts -> ram1_we high on wr_addr 0,1,2,3; state FULL; wr_ready=0.
REQ-036 FULL, then frame_start -> next cycle swap_done=1 and rd_bank=1; following cycle state FILL, ram0 becomes the write bank.
REQ-037 rd_active held for 6 cycles after a swap -> rd_addr sequence 0,1,2,3,0,1 on the new rd_bank re; the other re stays 0.
REQ-038 frame_start with only 2 entries written -> no swap, rd_addr=0, stale_cnt=1 (macro defined); fill then resumes at wr_addr 2.
REQ-039 4th accept coincident with frame_start -> direct SWAP, stale_cnt unchanged.
REQ-040 Assert resetn after 3 accepts -> all outputs at reset values; the next accept writes ram1 at address 0.
